// File: rtl/cpu86_trace_pkg.sv
// cpu86_trace_pkg
//   Shared types for the cpu86 execution-stage retirement trace tap:
//   opcode classes, architectural register ids, STACKU sub-op codes and
//   the packed descriptor that travels from dispatch to the trace record.
package cpu86_trace_pkg;

  typedef enum logic [4:0] {
    MOVU    = 5'd0,
    MOVR    = 5'd1,
    MOVM    = 5'd2,
    MOVI    = 5'd3,
    ALUR    = 5'd4,
    ALUI    = 5'd5,
    ALUM    = 5'd6,
    INCDEC  = 5'd7,
    MULDIV  = 5'd8,
    SHIFTU  = 5'd9,
    STACKU  = 5'd10,
    JMPU    = 5'd11,
    JCCU    = 5'd12,
    CALLU   = 5'd13,
    RETU    = 5'd14,
    LOOPU   = 5'd15,
    STRU    = 5'd16,
    IOU     = 5'd17,
    FLAGU   = 5'd18,
    SEGU    = 5'd19,
    INTU    = 5'd20,
    HLTU    = 5'd21,
    NOPU    = 5'd22,
    ILLEGAL = 5'd23
  } opcode_t;

  typedef enum logic [3:0] {
    AX = 4'd0,
    BX = 4'd1,
    CX = 4'd2,
    DX = 4'd3,
    BP = 4'd4,
    SP = 4'd5,
    SI = 4'd6,
    DI = 4'd7,
    ES = 4'd8,
    CS = 4'd9,
    SS = 4'd10,
    DS = 4'd11,
    FL = 4'd12
  } reg_t;

  // Sub-op codes carried in the code field when op == STACKU.
  typedef enum logic [3:0] {
    POPM  = 4'd0,
    POPR  = 4'd1,
    POPA  = 4'd2,
    PUSHR = 4'd3,
    PUSHI = 4'd4,
    PUSHM = 4'd5,
    PUSHA = 4'd6,
    ENTER = 4'd7,
    LEAVE = 4'd8
  } stack_code_t;

  typedef struct packed {
    opcode_t     op;
    logic [3:0]  code;
    logic [15:0] cs;
    logic [15:0] ip;
    reg_t        sreg;
    reg_t        dreg;
  } trace_desc_t;

endpackage

// File: rtl/cpu86_trace_fifo.sv
// cpu86_trace_fifo
//   Circular buffer of pending instruction descriptors, DEPTH entries
//   (power of two, 2..16). Head entry is presented combinationally on
//   rd_data; a pop consumes it at the next rising edge.
// Ports
//   clk, resetn      clock, async active-low reset
//   push, wr_data    enqueue (ignored when full or flushing)
//   pop, rd_data     dequeue head (ignored when empty)
//   flush            drop every queued entry; a same-cycle pop still sees
//                    the head on rd_data, a same-cycle push is discarded
//   count, full, empty  occupancy status
module cpu86_trace_fifo
  import cpu86_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  trace_desc_t            wr_data,
  input  logic                   pop,
  output trace_desc_t            rd_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  trace_desc_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cpu86_exec_trace_capture.sv
// cpu86_exec_trace_capture
//   Retirement trace tap. Dispatched descriptors are queued; each in-order
//   retire pulse pops the oldest into capture stage S1, and one cycle later
//   S2 snapshots the register file (write-back has landed by then) together
//   with the descriptor and strobes vld_valid for one cycle.
// Ports
//   clk, resetn                 clock, async active-low reset
//   instr_valid/instr_ready     dispatch handshake; ready = queue not full
//   instr_op..instr_dreg        descriptor fields
//   retire_valid                oldest outstanding instruction retired
//   flush                       discard queued descriptors
//   reg_ax..reg_fl              architectural register file
//   vld_valid, vld_*            per-retire trace record (held between strobes)
//   trace_err                   sticky: retire seen with an empty queue
module cpu86_exec_trace_capture
  import cpu86_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  instr_op,
  input  logic [3:0]  instr_code,
  input  logic [15:0] instr_cs,
  input  logic [15:0] instr_ip,
  input  logic [3:0]  instr_sreg,
  input  logic [3:0]  instr_dreg,
  input  logic        retire_valid,
  input  logic        flush,
  input  logic [15:0] reg_ax,
  input  logic [15:0] reg_bx,
  input  logic [15:0] reg_cx,
  input  logic [15:0] reg_dx,
  input  logic [15:0] reg_bp,
  input  logic [15:0] reg_sp,
  input  logic [15:0] reg_si,
  input  logic [15:0] reg_di,
  input  logic [15:0] reg_fl,
  output logic        vld_valid,
  output logic [4:0]  vld_op,
  output logic [3:0]  vld_code,
  output logic [15:0] vld_cs,
  output logic [15:0] vld_ip,
  output logic [15:0] vld_ax,
  output logic [15:0] vld_bx,
  output logic [15:0] vld_cx,
  output logic [15:0] vld_dx,
  output logic [15:0] vld_bp,
  output logic [15:0] vld_sp,
  output logic [15:0] vld_si,
  output logic [15:0] vld_di,
  output logic [15:0] vld_fl,
  output logic [3:0]  vld_sreg,
  output logic [3:0]  vld_dreg,
  output logic        trace_err
);

  trace_desc_t            in_desc;
  trace_desc_t            head_desc;
  trace_desc_t            s1_desc;
  trace_desc_t            s2_desc;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   q_push;
  logic                   q_pop;
  logic                   underflow;
  logic                   s1_valid;

  assign in_desc = '{
    op:   opcode_t'(instr_op),
    code: instr_code,
    cs:   instr_cs,
    ip:   instr_ip,
    sreg: reg_t'(instr_sreg),
    dreg: reg_t'(instr_dreg)
  };

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // opens the queue combinationally.
  assign instr_ready = !q_full;
  assign q_push      = instr_valid && instr_ready;
  assign q_pop       = retire_valid && (q_count != '0);
  assign underflow   = retire_valid && q_empty;

  cpu86_trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (q_push),
    .wr_data(in_desc),
    .pop    (q_pop),
    .rd_data(head_desc),
    .flush  (flush),
    .count  (q_count),
    .full   (q_full),
    .empty  (q_empty)
  );

  // S1: descriptor of the instruction that retired last cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_desc  <= '0;
    end else begin
      s1_valid <= q_pop;
      if (q_pop) s1_desc <= head_desc;
    end
  end

  // S2: record register; fields only move on a strobe cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_valid <= 1'b0;
      s2_desc   <= '0;
      vld_ax    <= '0;
      vld_bx    <= '0;
      vld_cx    <= '0;
      vld_dx    <= '0;
      vld_bp    <= '0;
      vld_sp    <= '0;
      vld_si    <= '0;
      vld_di    <= '0;
      vld_fl    <= '0;
    end else begin
      vld_valid <= s1_valid;
      if (s1_valid) begin
        s2_desc <= s1_desc;
        vld_ax  <= reg_ax;
        vld_bx  <= reg_bx;
        vld_cx  <= reg_cx;
        vld_dx  <= reg_dx;
        vld_bp  <= reg_bp;
        vld_sp  <= reg_sp;
        vld_si  <= reg_si;
        vld_di  <= reg_di;
        vld_fl  <= reg_fl;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trace_err <= 1'b0;
    end else if (underflow) begin
      trace_err <= 1'b1;
    end
  end

  assign vld_op   = s2_desc.op;
  assign vld_code = s2_desc.code;
  assign vld_cs   = s2_desc.cs;
  assign vld_ip   = s2_desc.ip;
  assign vld_sreg = s2_desc.sreg;
  assign vld_dreg = s2_desc.dreg;

endmodule

// File: tb/tb_cpu86_exec_trace_capture.sv
module tb_cpu86_exec_trace_capture;
  import cpu86_trace_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_op;
  logic [3:0]  instr_code;
  logic [15:0] instr_cs;
  logic [15:0] instr_ip;
  logic [3:0]  instr_sreg;
  logic [3:0]  instr_dreg;
  logic        retire_valid;
  logic        flush;
  logic [15:0] reg_ax, reg_bx, reg_cx, reg_dx, reg_bp, reg_sp, reg_si, reg_di, reg_fl;
  logic        vld_valid;
  logic [4:0]  vld_op;
  logic [3:0]  vld_code;
  logic [15:0] vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl;
  logic [3:0]  vld_sreg, vld_dreg;
  logic        trace_err;

  cpu86_exec_trace_capture #(
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_code(instr_code),
    .instr_cs(instr_cs), .instr_ip(instr_ip),
    .instr_sreg(instr_sreg), .instr_dreg(instr_dreg),
    .retire_valid(retire_valid), .flush(flush),
    .reg_ax(reg_ax), .reg_bx(reg_bx), .reg_cx(reg_cx), .reg_dx(reg_dx),
    .reg_bp(reg_bp), .reg_sp(reg_sp), .reg_si(reg_si), .reg_di(reg_di),
    .reg_fl(reg_fl),
    .vld_valid(vld_valid), .vld_op(vld_op), .vld_code(vld_code),
    .vld_cs(vld_cs), .vld_ip(vld_ip),
    .vld_ax(vld_ax), .vld_bx(vld_bx), .vld_cx(vld_cx), .vld_dx(vld_dx),
    .vld_bp(vld_bp), .vld_sp(vld_sp), .vld_si(vld_si), .vld_di(vld_di),
    .vld_fl(vld_fl), .vld_sreg(vld_sreg), .vld_dreg(vld_dreg),
    .trace_err(trace_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  code;
    logic [15:0] cs, ip, ax, bx, cx, dx, bp, sp, si, di, fl;
    logic [3:0]  sreg, dreg;
  } rec_t;

  typedef struct {
    rec_t r;
    int   cyc;
  } sb_ent_t;

  typedef struct {
    logic        push;
    logic [15:0] ip;
    logic        ret;
    logic        fl;
    logic        exp_ready;
    logic        exp_vld;
  } vec_t;

  trace_desc_t mq[$];
  sb_ent_t     sb[$];
  vec_t        tbl[14];
  int          checks   = 0;
  int          failures = 0;
  logic        merr     = 1'b0;
  int          ovr_cyc  = -1;
  logic        o_rdy, o_vld;

  function automatic logic [15:0] reg_val(int k, int j);
    if (k == ovr_cyc && j == 1) return 16'h1234;
    if (k == ovr_cyc && j == 5) return 16'hFFFC;
    return 16'((k * 263) ^ (j * 7985) ^ 16'h5A00);
  endfunction

  function automatic trace_desc_t mkd(opcode_t op, logic [3:0] code, logic [15:0] cs,
                                      logic [15:0] ip, reg_t s, reg_t d);
    trace_desc_t t;
    t.op = op; t.code = code; t.cs = cs; t.ip = ip; t.sreg = s; t.dreg = d;
    return t;
  endfunction

  function automatic rec_t mk_rec(trace_desc_t d, int k);
    rec_t r;
    r.op = d.op; r.code = d.code; r.cs = d.cs; r.ip = d.ip; r.sreg = d.sreg; r.dreg = d.dreg;
    r.ax = reg_val(k, 0); r.bx = reg_val(k, 1); r.cx = reg_val(k, 2);
    r.dx = reg_val(k, 3); r.bp = reg_val(k, 4); r.sp = reg_val(k, 5);
    r.si = reg_val(k, 6); r.di = reg_val(k, 7); r.fl = reg_val(k, 8);
    return r;
  endfunction

  function automatic rec_t dut_rec();
    rec_t r;
    r.op = vld_op; r.code = vld_code; r.cs = vld_cs; r.ip = vld_ip;
    r.sreg = vld_sreg; r.dreg = vld_dreg;
    r.ax = vld_ax; r.bx = vld_bx; r.cx = vld_cx; r.dx = vld_dx; r.bp = vld_bp;
    r.sp = vld_sp; r.si = vld_si; r.di = vld_di; r.fl = vld_fl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_record();
    sb_ent_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL record_missing: got none expected ip %0h at cycle %0d", e.r.ip, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("vld_strobe", vld_valid, 1'b1);
      if (vld_valid) chk("record", dut_rec(), e.r);
    end else begin
      chk("vld_idle", vld_valid, 1'b0);
    end
  endtask

  // One clock of stimulus; model updated as inputs are driven, outputs
  // checked at the falling edge, returns just after the next rising edge.
  task automatic step(input logic push, input trace_desc_t d, input logic ret, input logic fl,
                      output logic obs_ready, output logic obs_vld);
    logic        exp_ready;
    logic        err_nxt;
    trace_desc_t hd;
    sb_ent_t     e;
    instr_valid  = push;
    instr_op     = d.op;
    instr_code   = d.code;
    instr_cs     = d.cs;
    instr_ip     = d.ip;
    instr_sreg   = d.sreg;
    instr_dreg   = d.dreg;
    retire_valid = ret;
    flush        = fl;
    reg_ax = reg_val(cyc, 0); reg_bx = reg_val(cyc, 1); reg_cx = reg_val(cyc, 2);
    reg_dx = reg_val(cyc, 3); reg_bp = reg_val(cyc, 4); reg_sp = reg_val(cyc, 5);
    reg_si = reg_val(cyc, 6); reg_di = reg_val(cyc, 7); reg_fl = reg_val(cyc, 8);
    exp_ready = (mq.size() < DEPTH);
    err_nxt   = 1'b0;
    if (ret) begin
      if (mq.size() > 0) begin
        hd    = mq.pop_front();
        e.r   = mk_rec(hd, cyc + 1);
        e.cyc = cyc + 2;
        sb.push_back(e);
      end else begin
        err_nxt = 1'b1;
      end
    end
    if (fl) mq.delete();
    else if (push && exp_ready) mq.push_back(d);
    @(negedge clk);
    obs_ready = instr_ready;
    obs_vld   = vld_valid;
    chk("instr_ready", instr_ready, exp_ready);
    chk("trace_err", trace_err, merr);
    check_record();
    @(posedge clk);
    #1;
    merr = merr | err_nxt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, o_rdy, o_vld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 16'h0030, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'h0031, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0032, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0033, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'h0034, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

    resetn = 1'b0;
    instr_valid = 1'b0; instr_op = '0; instr_code = '0; instr_cs = '0; instr_ip = '0;
    instr_sreg = '0; instr_dreg = '0; retire_valid = 1'b0; flush = 1'b0;
    reg_ax = '0; reg_bx = '0; reg_cx = '0; reg_dx = '0; reg_bp = '0;
    reg_sp = '0; reg_si = '0; reg_di = '0; reg_fl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld_valid", vld_valid, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_trace_err", trace_err, 1'b0);
    chk("rst_vld_ip", vld_ip, 16'h0000);
    chk("rst_vld_ax", vld_ax, 16'h0000);
    chk("rst_vld_fl", vld_fl, 16'h0000);
    chk("rst_vld_sreg", vld_sreg, 4'd0);
    chk("rst_vld_dreg", vld_dreg, 4'd0);

    // Single instruction, retire three cycles after dispatch.
    ovr_cyc = cyc + 4;
    step(1'b1, mkd(STACKU, PUSHR, 16'hF000, 16'h0100, BX, SP), 1'b0, 1'b0, o_rdy, o_vld);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    idle(5);
    chk("hold_ip", vld_ip, 16'h0100);
    chk("hold_bx", vld_bx, 16'h1234);
    chk("hold_sp", vld_sp, 16'hFFFC);
    chk("hold_op", vld_op, 5'(STACKU));

    // Fill to full, held fifth offer, drain in order.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].push, mkd(MOVR, 4'h2, 16'h1000, tbl[i].ip, CX, DX),
           tbl[i].ret, tbl[i].fl, o_rdy, o_vld);
      chk($sformatf("tbl%0d_ready", i), o_rdy, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_vld", i), o_vld, tbl[i].exp_vld);
    end
    idle(2);

    // Streaming: push and retire every cycle, occupancy stays at one.
    step(1'b1, mkd(ALUR, 4'h1, 16'h0000, 16'h0000, AX, CX), 1'b0, 1'b0, o_rdy, o_vld);
    for (int i = 1; i < 20; i++)
      step(1'b1, mkd(ALUR, 4'h1, 16'h0000, 16'(i), AX, CX), 1'b1, 1'b0, o_rdy, o_vld);
    step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    idle(3);

    // Flush together with retire; the push in the flush cycle is dropped.
    step(1'b1, mkd(JCCU, 4'h3, 16'h0800, 16'h0010, SI, DI), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b1, mkd(JCCU, 4'h3, 16'h0800, 16'h0012, SI, DI), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b1, mkd(JCCU, 4'h3, 16'h0800, 16'h0014, SI, DI), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b1, mkd(JCCU, 4'h3, 16'h0800, 16'h0099, SI, DI), 1'b1, 1'b1, o_rdy, o_vld);
    step(1'b1, mkd(INTU, 4'h0, 16'h0000, 16'h2000, BP, FL), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    idle(4);

    // Underflow: error sets and stays set.
    step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    idle(3);
    chk("err_sticky", trace_err, 1'b1);
    step(1'b1, mkd(MOVU, 4'h0, 16'h0000, 16'h0300, AX, BX), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    idle(3);
    chk("err_sticky2", trace_err, 1'b1);

    // Async reset while S1 holds a retired descriptor.
    step(1'b1, mkd(MOVI, 4'h1, 16'h0000, 16'h0400, AX, AX), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b1, mkd(MOVI, 4'h1, 16'h0000, 16'h0402, AX, AX), 1'b0, 1'b0, o_rdy, o_vld);
    step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    instr_valid = 1'b0; retire_valid = 1'b0; flush = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_vld_valid", vld_valid, 1'b0);
    chk("arst_trace_err", trace_err, 1'b0);
    mq.delete();
    sb.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_vld_n2", vld_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready", instr_ready, 1'b1);
    chk("arst_vld_after", vld_valid, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, mkd(SEGU, 4'h2, 16'h0100, 16'(16'h0500 + i), DS, ES), 1'b0, 1'b0, o_rdy, o_vld);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, o_rdy, o_vld);
    idle(4);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu86_exec_trace_capture.md
# cpu86_exec_trace_capture

Retirement trace tap for the cpu86 execution stage. It queues each dispatched instruction's descriptor (op, code, CS:IP, source/destination register), matches it to the exec unit's in-order retire pulse, and snapshots the architectural register file after the write-back lands. It then presents one `vld_*` record per retired instruction to the golden-model register checker directly downstream.

## Interface
- `DEPTH`, 4: pending-descriptor queue depth; power of two, 2..16.
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  descriptor offered by dispatch.
- `instr_ready`  out  1  queue can accept; equals `count < DEPTH`.
- `instr_op`  in  5  opcode class (`opcode_t`).
- `instr_code`  in  4  sub-op code.
- `instr_cs`, `instr_ip`  in  16 each  CS:IP of the instruction.
- `instr_sreg`, `instr_dreg`  in  4 each  source/dest register (`reg_t`).
- `retire_valid`  in  1  oldest outstanding instruction completed this cycle, in order.
- `flush`  in  1  discard all non-retiring queued descriptors (taken jump, interrupt).
- `reg_ax`, `reg_bx`, `reg_cx`, `reg_dx`, `reg_bp`, `reg_sp`, `reg_si`, `reg_di`, `reg_fl`  in  16 each  register file outputs.
- `vld_valid`  out  1  one-cycle record strobe.
- `vld_op` 5, `vld_code` 4, `vld_cs`/`vld_ip`/`vld_ax`/`vld_bx`/`vld_cx`/`vld_dx`/`vld_bp`/`vld_sp`/`vld_si`/`vld_di`/`vld_fl` 16, `vld_sreg`/`vld_dreg` 4  out  record fields.
- `trace_err`  out  1  sticky: retire with empty queue.

## Operation
- Push: `instr_valid && instr_ready` writes the descriptor at `wr_ptr`, `count+1`.
- Retire: `retire_valid` with `count > 0` pops the head into capture stage S1 (`s1_valid=1`, descriptor latched), `count-1`.
- Retire with `count == 0`: no pop, no record; `trace_err` sets and holds until reset.
- Push and pop in the same cycle: both happen, count unchanged. No bypass: a descriptor must be queued at least one cycle before its retire.
- Full: `instr_ready=0`; an offered descriptor waits in dispatch. A same-cycle pop does not raise ready combinationally.
- Flush: the next state is `count=0`, `rd_ptr=wr_ptr`. If the same cycle has `retire_valid`, the head is popped into S1 first. A push in the flush cycle is also discarded.
- Capture: S1 to S2 on the next edge. S2 samples all `reg_*` inputs, which hold the retired instruction's write-back by then, and the S1 descriptor. It drives `vld_valid=1` for exactly one cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
- Back-to-back retires produce back-to-back `vld_valid` pulses. The record path has no stall; the checker always accepts.

## Timing
- Reset (async assert, sync release by top-level): `count=0`, pointers 0, `s1_valid=0`, `vld_valid=0`, all `vld_*` data 0, `vld_sreg`/`vld_dreg`=AX (0), `trace_err=0`, `instr_ready=1` once `resetn=1`.
- Reset asserted mid-operation clears the queue and pipeline immediately. `vld_valid` drops within the same cycle.
- Latency: `retire_valid` at cycle N gives `vld_valid` at N+2. Register fields are sampled at the N+1→N+2 edge.
- Minimum dispatch-to-retire spacing is 1 cycle (push at N, retire at N+1 is legal).
- `vld_*` data holds between strobes. It changes only on a `vld_valid` cycle.

## Structure
- Package `cpu86_trace_pkg`:
  - `opcode_t` (MOVU..ILLEGAL, 5-bit)
  - `reg_t` (AX=0..FL=12)
  - STACKU sub-codes (POPM, POPR, POPA, PUSHR, PUSHI, PUSHM, PUSHA, ENTER, LEAVE)
  - packed struct `trace_desc_t` {op, code, cs, ip, sreg, dreg}
- Sub-module `cpu86_trace_fifo`: parameterised `trace_desc_t` circular buffer with push/pop/flush, `count`, `full`, `empty`. The top level holds the S1/S2 capture registers and the error flag.

## Test plan
- Single instruction: push {STACKU, PUSHR, CS=F000, IP=0100, sreg=BX}, retire 3 cycles later with `reg_bx`=1234, `reg_sp`=FFFC at N+1 → one `vld_valid` at N+2 with `vld_ip`=0100, `vld_bx`=1234, `vld_sp`=FFFC.
- Fill: push 4 descriptors with no retire → `instr_ready=0` after the 4th. A 5th offer is held. Retire once → ready returns the next cycle, and the 5th pushes after that. Records come out in IP order.
- Streaming: push and retire every cycle for 20 cycles (IP 0000..0013) → 20 consecutive `vld_valid` cycles, IPs in order, count stays constant.
- Flush: 3 queued (IP 10, 12, 14), `flush` together with `retire_valid` → one record (IP 10), count=0. A new push at IP 2000 then retires as the next record.
- Underflow: `retire_valid` with an empty queue → no `vld_valid`, `trace_err=1` and it stays set until reset.
- Async reset: assert `resetn=0` mid-cycle while `s1_valid=1` → `vld_valid` stays 0, count=0 immediately. After release, `instr_ready=1`.
